rcc_linepos: RTL and testbench

- Downstream consumer of the 8-channel RC sensor timer block.
- Accepts one frame of eight 8-bit charge-time counts per poll, in channel order 0..7.
- Computes the frame total and a weighted-centroid line position (0..224) with a sequential 8-step restoring divider, and flags "line lost" when the total is below a host-set threshold.
- Results are exposed on the standard peripheral register bus, with autosend on poll.

---
 rtl/rcc_linepos.sv | 187 ++++++++++++++++++
 tb/tb_rcc_linepos.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcc_linepos.sv
// rtl/rcc_linepos.sv - RC sensor frame accumulator with centroid divider and register bus
module rcc_linepos #(
  parameter logic [7:0] THRESH_RST = 8'h10,
  parameter int         WSTEP      = 32
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       WE_I,
  input  logic       TGA_I,
  input  logic       STB_I,
  input  logic [7:0] ADR_I,
  output logic       STALL_O,
  output logic       ACK_O,
  input  logic [7:0] DAT_I,
  output logic [7:0] DAT_O,
  input  logic       s_valid,
  input  logic [2:0] s_idx,
  input  logic [7:0] s_val,
  input  logic       s_last,
  output logic       s_ready
);

  typedef enum logic [1:0] {ACCUM, DIVIDE, DONE} state_t;

  state_t      state;
  logic [2:0]  expected;
  logic [10:0] den;
  logic [17:0] num;
  logic [10:0] rem;
  logic [7:0]  qsh;
  logic [2:0]  step;
  logic        lost_pend;

  logic [7:0]  position;
  logic [10:0] sum;
  logic        lost;
  logic        err;
  logic [3:0]  frmcnt;
  logic [7:0]  threshold;
  logic        data_avail;

  logic        myaddr;
  logic        reg_rd;
  logic        reg_wr;
  logic        xfer;
  logic        seq_ok;
  logic [17:0] wprod;
  logic [10:0] den_n;
  logic [17:0] num_n;
  logic        frame_ok;
  logic [11:0] trial;
  logic        fits;
  logic [10:0] diff;
  logic [7:0]  rd_data;

  assign myaddr  = STB_I & (ADR_I[7:4] == 4'h0);
  assign reg_rd  = myaddr & TGA_I & ~WE_I;
  assign reg_wr  = myaddr & TGA_I & WE_I & (ADR_I[3:0] == 4'h4);
  assign STALL_O = 1'b0;
  assign ACK_O   = myaddr;

  assign xfer   = s_valid & s_ready;
  // A sample is in sequence only if it is the next channel and s_last marks exactly channel 7.
  assign seq_ok = (s_idx == expected) & (s_last == (s_idx == 3'd7));
  assign wprod  = 18'(s_val) * 18'(s_idx) * 18'(WSTEP);
  assign den_n  = den + 11'(s_val);
  assign num_n  = num + wprod;
  // Threshold is in units of 8 counts; an all-zero frame is always lost.
  assign frame_ok = (den_n != 11'd0) && (den_n[10:3] >= threshold);

  // Restoring step: the partial remainder stays below den, so the trial fits in 12 bits.
  assign trial = {rem, qsh[7]};
  assign fits  = trial >= {1'b0, den};
  assign diff  = 11'(trial - {1'b0, den});

  // Register read mux for the low sixteen addresses.
  always_comb begin
    rd_data = 8'h00;
    case (ADR_I[3:0])
      4'h0: rd_data = position;
      4'h1: rd_data = {5'b0, sum[10:8]};
      4'h2: rd_data = sum[7:0];
      4'h3: rd_data = {frmcnt, 2'b00, err, lost};
      4'h4: rd_data = threshold;
      default: rd_data = 8'h00;
    endcase
  end

  // Bus output: register data, autosend count on poll, otherwise pass the bus through.
  always_comb begin
    DAT_O = DAT_I;
    if (reg_rd)
      DAT_O = rd_data;
    else if (myaddr & ~TGA_I & data_avail)
      DAT_O = 8'h04;
  end

  // Host-programmable lost-line threshold.
  always_ff @(posedge CLK_I) begin
    if (RST_I)
      threshold <= THRESH_RST;
    else if (reg_wr)
      threshold <= DAT_I;
  end

  // Frame FSM: accumulate, divide, publish; status clears from reads lose to same-cycle sets.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state      <= ACCUM;
      s_ready    <= 1'b1;
      expected   <= 3'd0;
      den        <= 11'd0;
      num        <= 18'd0;
      rem        <= 11'd0;
      qsh        <= 8'd0;
      step       <= 3'd0;
      lost_pend  <= 1'b0;
      position   <= 8'hFF;
      sum        <= 11'd0;
      lost       <= 1'b1;
      err        <= 1'b0;
      frmcnt     <= 4'd0;
      data_avail <= 1'b0;
    end else begin
      if (reg_rd) begin
        data_avail <= 1'b0;
        if (ADR_I[3:0] == 4'h3)
          err <= 1'b0;
      end
      case (state)
        ACCUM: begin
          if (xfer) begin
            if (!seq_ok) begin
              err      <= 1'b1;
              den      <= 11'd0;
              num      <= 18'd0;
              expected <= 3'd0;
            end else if (s_last) begin
              den      <= den_n;
              num      <= 18'd0;
              expected <= 3'd0;
              s_ready  <= 1'b0;
              if (frame_ok) begin
                rem       <= {1'b0, num_n[17:8]};
                qsh       <= num_n[7:0];
                step      <= 3'd0;
                lost_pend <= 1'b0;
                state     <= DIVIDE;
              end else begin
                lost_pend <= 1'b1;
                state     <= DONE;
              end
            end else begin
              den      <= den_n;
              num      <= num_n;
              expected <= expected + 3'd1;
            end
          end
        end
        DIVIDE: begin
          rem  <= fits ? diff : trial[10:0];
          qsh  <= {qsh[6:0], fits};
          step <= step + 3'd1;
          if (step == 3'd7)
            state <= DONE;
        end
        DONE: begin
          sum        <= den;
          position   <= lost_pend ? 8'hFF : qsh;
          lost       <= lost_pend;
          frmcnt     <= frmcnt + 4'd1;
          data_avail <= 1'b1;
          den        <= 11'd0;
          num        <= 18'd0;
          expected   <= 3'd0;
          s_ready    <= 1'b1;
          state      <= ACCUM;
        end
        default: begin
          state   <= ACCUM;
          s_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rcc_linepos.sv
// tb/tb_rcc_linepos.sv - self-checking bench for rcc_linepos
module tb_rcc_linepos;

  logic       clk = 1'b0;
  logic       rst;
  logic       we, tga, stb;
  logic [7:0] adr, dat_i, dat_o;
  logic       stall, ack;
  logic       s_valid, s_last, s_ready;
  logic [2:0] s_idx;
  logic [7:0] s_val;

  rcc_linepos dut (
    .CLK_I(clk), .RST_I(rst), .WE_I(we), .TGA_I(tga), .STB_I(stb), .ADR_I(adr),
    .STALL_O(stall), .ACK_O(ack), .DAT_I(dat_i), .DAT_O(dat_o),
    .s_valid(s_valid), .s_idx(s_idx), .s_val(s_val), .s_last(s_last), .s_ready(s_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  v[8];
    logic [7:0]  thr;
    logic [7:0]  pos;
    logic [10:0] sum;
    logic        lost;
    int          lat;
  } vec_t;

  vec_t       tbl[8];
  int         checks = 0;
  int         errors = 0;
  int         frm_model = 0;
  logic       lost_model = 1'b1;
  string      tag = "init";
  logic [7:0] d;
  int         n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s actual=%0h required=%0h", tag, name, act, exp);
    end
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] rd);
    @(negedge clk); stb = 1'b1; tga = 1'b1; we = 1'b0; adr = a;
    #1 rd = dat_o;
    @(negedge clk); stb = 1'b0; tga = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] wd);
    @(negedge clk); stb = 1'b1; tga = 1'b1; we = 1'b1; adr = a; dat_i = wd;
    @(negedge clk); stb = 1'b0; tga = 1'b0; we = 1'b0; dat_i = 8'h5A;
  endtask

  task automatic poll(output logic [7:0] rd);
    @(negedge clk); stb = 1'b1; tga = 1'b0; we = 1'b0; adr = 8'h00; dat_i = 8'h5A;
    #1 rd = dat_o;
    stb = 1'b0;
  endtask

  task automatic send_sample(input logic [2:0] i, input logic [7:0] v, input logic l);
    int k = 0;
    @(negedge clk); s_valid = 1'b1; s_idx = i; s_val = v; s_last = l;
    while (s_ready !== 1'b1 && k < 50) begin
      @(negedge clk); k++;
    end
    if (k >= 50) check("sready_wait", k, 0);
    @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] v[8], input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(negedge clk); s_valid = 1'b0; end
      send_sample(3'(i), v[i], i == 7);
    end
  endtask

  // Counts falling edges from the accepting edge until autosend appears on poll.
  task automatic wait_result(output int cnt);
    bit seen = 0;
    cnt = 0;
    while (!seen && cnt < 40) begin
      @(negedge clk); s_valid = 1'b0; cnt++;
      stb = 1'b1; tga = 1'b0; we = 1'b0; adr = 8'h00; dat_i = 8'h5A;
      #1 if (dat_o == 8'h04) seen = 1;
      stb = 1'b0;
    end
    if (!seen) cnt = 99;
  endtask

  task automatic check_regs(input logic [7:0] pos, input logic [10:0] sum, input logic lst, input logic e);
    logic [7:0] rd;
    bus_read(8'h00, rd); check("pos", rd, pos);
    bus_read(8'h01, rd); check("sum_hi", rd, {5'b0, sum[10:8]});
    bus_read(8'h02, rd); check("sum_lo", rd, sum[7:0]);
    bus_read(8'h03, rd); check("status", rd, {frm_model[3:0], 2'b00, e, lst});
  endtask

  task automatic reset_checks();
    logic [7:0] rd;
    check("s_ready", s_ready, 1'b1);
    bus_read(8'h00, rd); check("r0", rd, 8'hFF);
    bus_read(8'h01, rd); check("r1", rd, 8'h00);
    bus_read(8'h02, rd); check("r2", rd, 8'h00);
    bus_read(8'h03, rd); check("r3", rd, 8'h01);
    bus_read(8'h04, rd); check("r4", rd, 8'h10);
    poll(rd); check("poll", rd, 8'h5A);
  endtask

  // Reference: centroid of channel weights i*32 over the frame, or lost below threshold.
  task automatic model(input logic [7:0] v[8], input logic [7:0] thr,
                       output logic [7:0] pos, output logic [10:0] sum, output logic lst);
    int s = 0, w = 0;
    for (int i = 0; i < 8; i++) begin
      s += int'(v[i]);
      w += int'(v[i]) * i * 32;
    end
    lst = (s == 0) || ((s / 8) < int'(thr));
    pos = lst ? 8'hFF : 8'(w / s);
    sum = 11'(s);
  endtask

  task automatic run_vec(input int i);
    logic [7:0] fv[8];
    logic [7:0] rd;
    int         cnt;
    for (int c = 0; c < 8; c++) fv[c] = tbl[i].v[c];
    tag = $sformatf("vec%0d", i);
    bus_write(8'h04, tbl[i].thr);
    bus_read(8'h03, rd);
    send_frame(fv, 0);
    wait_result(cnt);
    frm_model++;
    lost_model = tbl[i].lost;
    check("latency", cnt, tbl[i].lat);
    check_regs(tbl[i].pos, tbl[i].sum, tbl[i].lost, 1'b0);
    poll(rd); check("poll_cleared", rd, 8'h5A);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  fv[8];
    logic [7:0]  epos, thr;
    logic [10:0] esum;
    logic        elost;

    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < 8; c++) tbl[i].v[c] = 8'd0;
      tbl[i].lost = 1'b0;
      tbl[i].lat  = 10;
      tbl[i].thr  = 8'h10;
    end
    tbl[0].v[3] = 8'd100; tbl[0].thr = 8'h0C; tbl[0].pos = 8'h60; tbl[0].sum = 11'h064;
    tbl[1].v[2] = 8'd100; tbl[1].v[3] = 8'd100; tbl[1].pos = 8'h50; tbl[1].sum = 11'h0C8;
    for (int c = 0; c < 8; c++) tbl[2].v[c] = 8'd255;
    tbl[2].pos = 8'h70; tbl[2].sum = 11'h7F8;
    for (int c = 0; c < 8; c++) tbl[3].v[c] = 8'd1;
    tbl[3].pos = 8'hFF; tbl[3].sum = 11'd8; tbl[3].lost = 1'b1; tbl[3].lat = 2;
    for (int c = 0; c < 8; c++) tbl[4].v[c] = 8'd1;
    tbl[4].thr = 8'h00; tbl[4].pos = 8'h70; tbl[4].sum = 11'd8;
    tbl[5].thr = 8'h00; tbl[5].pos = 8'hFF; tbl[5].sum = 11'd0; tbl[5].lost = 1'b1; tbl[5].lat = 2;
    tbl[6].v[3] = 8'd100; tbl[6].thr = 8'h0D; tbl[6].pos = 8'hFF; tbl[6].sum = 11'h064;
    tbl[6].lost = 1'b1; tbl[6].lat = 2;
    tbl[7].v[7] = 8'd255; tbl[7].thr = 8'h1F; tbl[7].pos = 8'hE0; tbl[7].sum = 11'h0FF;

    rst = 1'b1; we = 1'b0; tga = 1'b0; stb = 1'b0; adr = 8'h00; dat_i = 8'h5A;
    s_valid = 1'b0; s_idx = 3'd0; s_val = 8'd0; s_last = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    tag = "reset";
    reset_checks();
    @(negedge clk); stb = 1'b1; tga = 1'b1; we = 1'b0; adr = 8'h14;
    #1 check("ack_other", ack, 1'b0); check("dat_other", dat_o, 8'h5A);
    adr = 8'h02;
    #1 check("ack_mine", ack, 1'b1); check("stall", stall, 1'b0);
    stb = 1'b0; tga = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i);

    tag = "err_order";
    bus_write(8'h04, 8'h10);
    send_sample(3'd0, 8'd40, 1'b0);
    send_sample(3'd1, 8'd40, 1'b0);
    send_sample(3'd3, 8'd40, 1'b0);
    for (int c = 0; c < 8; c++) fv[c] = tbl[1].v[c];
    send_frame(fv, 0);
    wait_result(n);
    frm_model++; lost_model = 1'b0;
    check("latency", n, 10);
    check_regs(8'h50, 11'h0C8, 1'b0, 1'b1);
    bus_read(8'h03, d); check("err_cleared", d, {frm_model[3:0], 4'b0000});

    tag = "err_nolast";
    for (int i = 0; i < 8; i++) send_sample(3'(i), 8'd9, 1'b0);
    @(negedge clk); s_valid = 1'b0;
    bus_read(8'h03, d); check("status", d, {frm_model[3:0], 4'b0010});
    bus_read(8'h03, d); check("cleared", d, {frm_model[3:0], 4'b0000});

    tag = "err_early_last";
    send_sample(3'd0, 8'd5, 1'b0);
    send_sample(3'd1, 8'd5, 1'b1);
    @(negedge clk); s_valid = 1'b0;
    bus_read(8'h03, d); check("status", d, {frm_model[3:0], 4'b0010});

    tag = "hold_divide";
    for (int c = 0; c < 8; c++) fv[c] = tbl[2].v[c];
    send_frame(fv, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); s_valid = 1'b1; s_idx = 3'd0; s_val = 8'd50; s_last = 1'b0;
      #1 check("s_ready_low", s_ready, 1'b0);
    end
    wait_result(n);
    frm_model++; lost_model = 1'b0;
    check("latency_rest", n, 5);
    check_regs(8'h70, 11'h7F8, 1'b0, 1'b0);
    run_vec(1);

    tag = "same_cycle";
    for (int c = 0; c < 8; c++) fv[c] = tbl[2].v[c];
    send_frame(fv, 0);
    repeat (8) begin @(negedge clk); s_valid = 1'b0; end
    bus_read(8'h00, d); check("old_pos", d, 8'h50);
    frm_model++;
    poll(d); check("avail_wins", d, 8'h04);
    check_regs(8'h70, 11'h7F8, 1'b0, 1'b0);

    tag = "reset_divide";
    send_frame(fv, 0);
    repeat (3) begin @(negedge clk); s_valid = 1'b0; end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    frm_model = 0; lost_model = 1'b1;
    reset_checks();
    repeat (12) @(negedge clk);
    poll(d); check("no_late_update", d, 8'h5A);
    bus_read(8'h00, d); check("pos_still_ff", d, 8'hFF);
    run_vec(1);

    for (int r = 0; r < 25; r++) begin
      tag = $sformatf("rand%0d", r);
      for (int c = 0; c < 8; c++)
        fv[c] = (r % 3 == 0) ? 8'($urandom_range(0, 8)) : 8'($urandom_range(0, 255));
      thr = 8'($urandom_range(0, 40));
      model(fv, thr, epos, esum, elost);
      bus_write(8'h04, thr);
      bus_read(8'h03, d);
      send_frame(fv, 1);
      wait_result(n);
      frm_model++; lost_model = elost;
      check("latency", n, elost ? 2 : 10);
      check_regs(epos, esum, elost, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
